// File: rtl/fsm_sleep_timed.sv
// ============================================================================
// Module      : fsm_sleep_timed
// Description : Sleep/wake Moore FSM with input qualifier, per-state dwell
//               counter, auto-timeouts and state-change strobe.
//               Optional wake counter enabled by defining WAKE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_sleep_timed #(
  parameter int CNT_WIDTH   = 8,
  parameter int NAP_LIMIT   = 10,
  parameter int SLEEP_LIMIT = 50,
  parameter int CLASS_LIMIT = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [2:0]           input_signal,
  output logic [5:0]           output_signal,
  output logic [2:0]           state_out,
  output logic [CNT_WIDTH-1:0] dwell,
  output logic                 state_changed
`ifdef WAKE_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] wake_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_NAP   = 3'b001,
    S_SLEEP = 3'b010,
    S_HIB   = 3'b011,
    S_WAKE  = 3'b100,
    S_CLASS = 3'b101
  } state_t;

  localparam logic [5:0] c_nothing = 6'b100000;
  localparam logic [5:0] c_snore   = 6'b100001;
  localparam logic [5:0] c_upset   = 6'b100010;
  localparam logic [5:0] c_learn   = 6'b100011;

  localparam logic [CNT_WIDTH-1:0] c_dwell_max  = '1;
  localparam logic [CNT_WIDTH-1:0] c_nap_last   = CNT_WIDTH'(NAP_LIMIT - 1);
  localparam logic [CNT_WIDTH-1:0] c_sleep_last = CNT_WIDTH'(SLEEP_LIMIT - 1);
  localparam logic [CNT_WIDTH-1:0] c_class_last = CNT_WIDTH'(CLASS_LIMIT - 1);

  // A limit that does not fit in the dwell counter could never be reached.
  if ((NAP_LIMIT >> CNT_WIDTH) != 0) begin : g_nap_limit_bad
    $error("fsm_sleep_timed: NAP_LIMIT does not fit in CNT_WIDTH");
  end
  if ((SLEEP_LIMIT >> CNT_WIDTH) != 0) begin : g_sleep_limit_bad
    $error("fsm_sleep_timed: SLEEP_LIMIT does not fit in CNT_WIDTH");
  end
  if ((CLASS_LIMIT >> CNT_WIDTH) != 0) begin : g_class_limit_bad
    $error("fsm_sleep_timed: CLASS_LIMIT does not fit in CNT_WIDTH");
  end

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_dwell;
  logic                   r_changed;
  state_t                 w_next;
  logic [2:0]             w_code;
  logic                   w_reentry;
  logic                   w_input_move;
  logic                   w_change;
  logic [5:0]             w_out;
`ifdef WAKE_COUNT_EN
  logic [CNT_WIDTH-1:0]   r_wake;
`endif

  always_comb begin
    w_code    = in_valid ? input_signal : 3'b000;
    w_next    = r_state;
    w_reentry = 1'b0;
    case (r_state)
      S_IDLE, S_CLASS: begin
        case (w_code)
          3'b000: w_next = r_state;
          3'b001: w_next = S_NAP;
          3'b010: w_next = S_SLEEP;
          3'b011: w_next = S_HIB;
          3'b100: begin
            w_next    = S_CLASS;
            w_reentry = (r_state == S_CLASS);
          end
          default: w_next = S_IDLE;
        endcase
      end
      S_NAP:   if (w_code[2]) w_next = S_WAKE;
      S_SLEEP: if (w_code >= 3'b101) w_next = S_WAKE;
      S_HIB:   if (w_code == 3'b111) w_next = S_WAKE;
      S_WAKE:  w_next = (w_code == 3'b100) ? S_CLASS : S_IDLE;
      default: w_next = S_IDLE;
    endcase

    // Timeouts only apply when the input did not already move the FSM.
    w_input_move = (w_next != r_state) || w_reentry;
    if (!w_input_move) begin
      if (r_state == S_NAP && NAP_LIMIT != 0 && r_dwell == c_nap_last)
        w_next = S_WAKE;
      else if (r_state == S_SLEEP && SLEEP_LIMIT != 0 && r_dwell == c_sleep_last)
        w_next = S_WAKE;
      else if (r_state == S_CLASS && CLASS_LIMIT != 0 && r_dwell == c_class_last)
        w_next = S_IDLE;
    end
    w_change = (w_next != r_state) || w_reentry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_dwell   <= '0;
      r_changed <= 1'b0;
`ifdef WAKE_COUNT_EN
      r_wake    <= '0;
`endif
    end else begin
      r_state   <= w_next;
      r_changed <= w_change;
      if (w_change)
        r_dwell <= '0;
      else if (r_dwell != c_dwell_max)
        r_dwell <= r_dwell + 1'b1;
`ifdef WAKE_COUNT_EN
      if (w_next == S_WAKE && r_state != S_WAKE && r_wake != c_dwell_max)
        r_wake <= r_wake + 1'b1;
`endif
    end
  end

  always_comb begin
    case (r_state)
      S_IDLE:               w_out = c_nothing;
      S_NAP, S_SLEEP, S_HIB: w_out = c_snore;
      S_WAKE:               w_out = c_upset;
      S_CLASS:              w_out = c_learn;
      default:              w_out = c_nothing;
    endcase
  end

  assign output_signal = reset ? c_nothing : w_out;
  assign state_out     = r_state;
  assign dwell         = r_dwell;
  assign state_changed = r_changed;
`ifdef WAKE_COUNT_EN
  assign wake_count    = r_wake;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fsm_sleep_timed.sv
// ============================================================================
// Module      : tb_fsm_sleep_timed
// Description : Self-checking bench for fsm_sleep_timed (vector table,
//               directed timed sequences, randomized run vs reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_sleep_timed;

  localparam int CW   = 8;
  localparam int NAPL = 10;
  localparam int SLPL = 50;
  localparam int CLSL = 40;
  localparam int DMAX = (1 << CW) - 1;

  localparam int ST_IDLE = 0, ST_NAP = 1, ST_SLEEP = 2, ST_HIB = 3, ST_WAKE = 4, ST_CLASS = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [2:0]    input_signal = 3'b000;
  logic [5:0]    output_signal;
  logic [2:0]    state_out;
  logic [CW-1:0] dwell;
  logic          state_changed;
`ifdef WAKE_COUNT_EN
  logic [CW-1:0] wake_count;
`endif

  always #5 clk = ~clk;

  fsm_sleep_timed #(
    .CNT_WIDTH(CW), .NAP_LIMIT(NAPL), .SLEEP_LIMIT(SLPL), .CLASS_LIMIT(CLSL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .input_signal(input_signal),
    .output_signal(output_signal),
    .state_out(state_out),
    .dwell(dwell),
    .state_changed(state_changed)
`ifdef WAKE_COUNT_EN
    ,
    .wake_count(wake_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (plain integers, unbounded dwell clipped at DMAX)
  int m_state = ST_IDLE;
  int m_dwell = 0;
  int m_chg   = 0;
  int m_wake  = 0;

  function automatic logic [5:0] out_of(input int s);
    case (s)
      ST_NAP, ST_SLEEP, ST_HIB: return 6'b100001;
      ST_WAKE:                  return 6'b100010;
      ST_CLASS:                 return 6'b100011;
      default:                  return 6'b100000;
    endcase
  endfunction

  function automatic int limit_of(input int s);
    case (s)
      ST_NAP:   return NAPL;
      ST_SLEEP: return SLPL;
      ST_CLASS: return CLSL;
      default:  return 0;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [2:0] c);
    int e, nxt, lim;
    bit moved;
    int tgt [4] = '{ST_NAP, ST_SLEEP, ST_HIB, ST_CLASS};
    if (r) begin
      m_state = ST_IDLE; m_dwell = 0; m_chg = 0; m_wake = 0;
      return;
    end
    e   = v ? int'(c) : 0;
    nxt = m_state;
    if (m_state == ST_IDLE || m_state == ST_CLASS) begin
      if (e >= 1 && e <= 4) nxt = tgt[e-1];
      else if (e >= 5)      nxt = ST_IDLE;
      moved = (nxt != m_state) || (m_state == ST_CLASS && e == 4);
    end else begin
      if (m_state == ST_NAP   && e >= 4) nxt = ST_WAKE;
      if (m_state == ST_SLEEP && e >= 5) nxt = ST_WAKE;
      if (m_state == ST_HIB   && e == 7) nxt = ST_WAKE;
      if (m_state == ST_WAKE)            nxt = (e == 4) ? ST_CLASS : ST_IDLE;
      if (m_state > ST_CLASS)            nxt = ST_IDLE;
      moved = (nxt != m_state);
    end
    lim = limit_of(m_state);
    if (!moved && lim != 0 && m_dwell == lim - 1) begin
      nxt   = (m_state == ST_CLASS) ? ST_IDLE : ST_WAKE;
      moved = 1'b1;
    end
    if (nxt == ST_WAKE && m_state != ST_WAKE && m_wake < DMAX) m_wake++;
    m_dwell = moved ? 0 : ((m_dwell < DMAX) ? m_dwell + 1 : DMAX);
    m_chg   = moved ? 1 : 0;
    m_state = nxt;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("state_out", 32'(state_out), 32'(m_state));
    check("output_signal", 32'(output_signal), 32'(out_of(m_state)));
    check("dwell", 32'(dwell), 32'(m_dwell));
    check("state_changed", 32'(state_changed), 32'(m_chg));
`ifdef WAKE_COUNT_EN
    check("wake_count", 32'(wake_count), 32'(m_wake));
`endif
  endtask

  // Apply inputs, clock once, sample 1ns after the edge, advance model.
  task automatic drive(input bit r, input bit v, input logic [2:0] c);
    reset = r; in_valid = v; input_signal = c;
    @(posedge clk);
    #1;
    model_step(r, v, c);
  endtask

  task automatic step(input bit r, input bit v, input logic [2:0] c);
    drive(r, v, c);
    check_model();
  endtask

  typedef struct {
    bit         r;
    bit         v;
    logic [2:0] c;
    logic [2:0] st;
    logic [5:0] o;
    int         d;
    bit         ch;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int cnt, pulses, w0;
    bit rr, vv;
    logic [2:0] cc;

    tbl.push_back(vec_t'{1, 0, 3'd0, 3'd0, 6'h20, 0, 0});
    tbl.push_back(vec_t'{1, 0, 3'd0, 3'd0, 6'h20, 0, 0});
    tbl.push_back(vec_t'{0, 0, 3'd0, 3'd0, 6'h20, 1, 0});
    tbl.push_back(vec_t'{0, 0, 3'd0, 3'd0, 6'h20, 2, 0});
    tbl.push_back(vec_t'{0, 0, 3'd0, 3'd0, 6'h20, 3, 0});
    tbl.push_back(vec_t'{0, 0, 3'd0, 3'd0, 6'h20, 4, 0});
    tbl.push_back(vec_t'{0, 1, 3'd1, 3'd1, 6'h21, 0, 1});
    tbl.push_back(vec_t'{0, 1, 3'd0, 3'd1, 6'h21, 1, 0});
    tbl.push_back(vec_t'{0, 1, 3'd5, 3'd4, 6'h22, 0, 1});
    tbl.push_back(vec_t'{0, 0, 3'd0, 3'd0, 6'h20, 0, 1});
    tbl.push_back(vec_t'{0, 1, 3'd2, 3'd2, 6'h21, 0, 1});
    tbl.push_back(vec_t'{0, 1, 3'd1, 3'd2, 6'h21, 1, 0});
    tbl.push_back(vec_t'{0, 1, 3'd7, 3'd4, 6'h22, 0, 1});
    tbl.push_back(vec_t'{0, 1, 3'd4, 3'd5, 6'h23, 0, 1});
    tbl.push_back(vec_t'{0, 1, 3'd4, 3'd5, 6'h23, 0, 1});
    tbl.push_back(vec_t'{0, 0, 3'd0, 3'd5, 6'h23, 1, 0});
    tbl.push_back(vec_t'{0, 1, 3'd3, 3'd3, 6'h21, 0, 1});
    tbl.push_back(vec_t'{0, 1, 3'd6, 3'd3, 6'h21, 1, 0});
    tbl.push_back(vec_t'{0, 1, 3'd7, 3'd4, 6'h22, 0, 1});
    tbl.push_back(vec_t'{0, 1, 3'd6, 3'd0, 6'h20, 0, 1});
    tbl.push_back(vec_t'{0, 1, 3'd5, 3'd0, 6'h20, 1, 0});
    tbl.push_back(vec_t'{0, 0, 3'd1, 3'd0, 6'h20, 2, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].c);
      check($sformatf("tbl%0d.state", i), 32'(state_out), 32'(tbl[i].st));
      check($sformatf("tbl%0d.out", i), 32'(output_signal), 32'(tbl[i].o));
      check($sformatf("tbl%0d.dwell", i), 32'(dwell), 32'(tbl[i].d));
      check($sformatf("tbl%0d.chg", i), 32'(state_changed), 32'(tbl[i].ch));
    end
`ifdef WAKE_COUNT_EN
    check("tbl.wake_count", 32'(wake_count), 32'd3);
`endif

    // NAP held exactly NAP_LIMIT cycles, then one WAKEUP cycle, then IDLE
    w0 = m_wake;
    step(0, 1, 3'd1);
    cnt    = (state_out == 3'd1) ? 1 : 0;
    pulses = state_changed ? 1 : 0;
    for (int k = 0; k < 14; k++) begin
      step(0, 0, 3'd0);
      if (state_out == 3'd1) cnt++;
      if (state_changed) pulses++;
    end
    check("nap_hold_cycles", 32'(cnt), 32'(NAPL));
    check("nap_pulses", 32'(pulses), 32'd3);
    check("nap_end_state", 32'(state_out), 32'd0);
    check("nap_wake_delta", 32'(m_wake - w0), 32'd1);

    // Input at the last SLEEP cycle beats the timeout: single WAKEUP entry
    w0 = m_wake;
    step(0, 1, 3'd2);
    for (int k = 0; k < SLPL - 1; k++) step(0, 0, 3'd0);
    check("sleep_dwell_last", 32'(dwell), 32'(SLPL - 1));
    step(0, 1, 3'd6);
    check("sleep_beat_state", 32'(state_out), 32'd4);
    step(0, 0, 3'd0);
    check("sleep_beat_idle", 32'(state_out), 32'd0);
    check("sleep_wake_delta", 32'(m_wake - w0), 32'd1);

    // Unqualified input ignored in HIBERNATE; dwell saturates
    step(0, 1, 3'd3);
    for (int k = 0; k < 300; k++) step(0, 0, 3'd7);
    check("hib_state", 32'(state_out), 32'd3);
    check("hib_dwell_sat", 32'(dwell), 32'(DMAX));
    step(0, 1, 3'd7);
    check("hib_wake", 32'(state_out), 32'd4);

    // WAKEUP -> ATTENDCLASS, re-entry at dwell 20, then timeout to IDLE
    step(0, 1, 3'd4);
    check("class_state", 32'(state_out), 32'd5);
    check("class_out", 32'(output_signal), 32'h23);
    for (int k = 0; k < 20; k++) step(0, 0, 3'd0);
    check("class_dwell20", 32'(dwell), 32'd20);
    step(0, 1, 3'd4);
    check("class_reentry_dwell", 32'(dwell), 32'd0);
    check("class_reentry_chg", 32'(state_changed), 32'd1);
    cnt = 1;
    for (int k = 0; k < 50; k++) begin
      step(0, 0, 3'd0);
      if (state_out == 3'd5) cnt++;
    end
    check("class_hold_cycles", 32'(cnt), 32'(CLSL));
    check("class_end_state", 32'(state_out), 32'd0);

    // Mid-operation reset in SLEEP at dwell 30
    step(0, 1, 3'd2);
    for (int k = 0; k < 30; k++) step(0, 0, 3'd0);
    check("rst_pre_dwell", 32'(dwell), 32'd30);
    reset = 1'b1;
    #1;
    check("rst_forced_out", 32'(output_signal), 32'h20);
    check("rst_pre_state", 32'(state_out), 32'd2);
    step(1, 1, 3'd7);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_dwell", 32'(dwell), 32'd0);
`ifdef WAKE_COUNT_EN
    check("rst_wake_count", 32'(wake_count), 32'd0);
`endif
    step(0, 0, 3'd0);

    // Randomized run against the reference model
    for (int k = 0; k < 3000; k++) begin
      rr = ($urandom_range(63) == 0);
      vv = ($urandom_range(3) == 0);
      cc = 3'($urandom_range(7));
      step(rr, vv, cc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
